// File: rtl/plot_arb_pkg.sv
// Shared widths, state encoding and per-requester pixel type for the plot arbiter.
package plot_arb_pkg;
  localparam int NUM_REQ   = 4;
  localparam int PTR_W     = 2;
  localparam int X_W       = 8;
  localparam int Y_W       = 7;
  localparam int C_W       = 3;
  localparam int X_MAX_DEF = 159;
  localparam int Y_MAX_DEF = 119;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] colour;
  } pixel_t;
endpackage

// File: rtl/plot_arbiter_rr_pick.sv
// Rotate-priority picker: first valid index searching upward from (ptr+1) mod NUM_REQ.
module rr_pick
  import plot_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   idx,
  output logic               found
);
  logic [PTR_W-1:0] cand;

  // Walk from the farthest offset down so the nearest valid one is written last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ptr + PTR_W'(k);
      if (valid[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/plot_arbiter.sv
// Four-requester round-robin pixel arbiter in front of a VGA adapter.
// Optional off-screen clipping is enabled with `define PLOT_ARB_CLIP_EN.
module plot_arbiter
  import plot_arb_pkg::*;
#(
  parameter int X_MAX   = X_MAX_DEF,
  parameter int Y_MAX   = Y_MAX_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_last,
  input  logic [NUM_REQ*X_W-1:0] req_x,
  input  logic [NUM_REQ*Y_W-1:0] req_y,
  input  logic [NUM_REQ*C_W-1:0] req_colour,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   plot,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [C_W-1:0]         colour,
  output logic [PTR_W-1:0]       grant_id,
  output logic                   busy
);
`ifdef PLOT_ARB_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  state_t           state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt, gnt_nxt;
  logic [7:0]       idle_cnt, idle_nxt;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_found;
  logic             accept, in_bounds;
  pixel_t           lane [NUM_REQ];
  pixel_t           sel;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane[i] = {req_x[i*X_W +: X_W], req_y[i*Y_W +: Y_W], req_colour[i*C_W +: C_W]};
  end

  rr_pick u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign sel       = lane[grant_id];
  assign busy      = (state == HOLD);
  assign accept    = busy && req_valid[grant_id];
  assign in_bounds = (int'(sel.x) <= X_MAX) && (int'(sel.y) <= Y_MAX);

  // Only the grantee is ever acknowledged; everyone else waits for the next arbitration.
  always_comb begin
    req_ready = '0;
    if (busy) req_ready[grant_id] = req_valid[grant_id];
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = grant_id;
    idle_nxt  = idle_cnt;
    case (state)
      ARB: begin
        if (pick_found) begin
          state_nxt = HOLD;
          ptr_nxt   = pick_idx;
          gnt_nxt   = pick_idx;
          idle_nxt  = '0;
        end
      end
      HOLD: begin
        if (accept) begin
          idle_nxt = '0;
          if (req_last[grant_id]) state_nxt = ARB;
        end else if (idle_cnt == 8'(TIMEOUT - 1)) begin
          // A silent grantee loses the grant so the others are not starved.
          state_nxt = ARB;
          idle_nxt  = '0;
        end else begin
          idle_nxt = idle_cnt + 8'd1;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ARB;
      ptr      <= PTR_W'(NUM_REQ - 1);
      grant_id <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      grant_id <= gnt_nxt;
      idle_cnt <= idle_nxt;
    end
  end

  // Clipped beats are still consumed; they just never strobe the adapter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
    end else begin
      plot <= accept && (!CLIP || in_bounds);
      if (accept) begin
        x      <= sel.x;
        y      <= sel.y;
        colour <= sel.colour;
      end
    end
  end
endmodule

// File: tb/tb_plot_arbiter.sv
// Self-checking bench for plot_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_plot_arbiter;
  localparam int TMO = 64;
  localparam int XM  = 159;
  localparam int YM  = 119;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  req_valid = '0, req_last = '0;
  logic [31:0] req_x = '0;
  logic [27:0] req_y = '0;
  logic [11:0] req_colour = '0;
  logic [3:0]  req_ready;
  logic        plot, busy;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic [1:0]  grant_id;

  plot_arbiter #(.X_MAX(XM), .Y_MAX(YM), .TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_last(req_last),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .req_ready(req_ready),
    .plot(plot), .x(x), .y(y), .colour(colour), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // source behaviour: remaining pixels, next pixel fields, stall and auto-refill flags
  int rem[4], px[4], py[4], pc[4];
  bit stall[4], refill[4];

  // reference model state and per-cycle expectations
  bit m_hold, m_plot;
  int m_g, m_ptr = 3, m_idle, m_gid, m_x, m_y, m_c;
  bit e_plot, e_busy;
  int e_x, e_y, e_c, e_gid;
  logic [3:0] e_ready;

  function automatic bit on_screen(input int xx, input int yy);
`ifdef PLOT_ARB_CLIP_EN
    return (xx <= XM) && (yy <= YM);
`else
    return 1'b1;
`endif
  endfunction

  task automatic clear_src();
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0; px[i] = 0; py[i] = 0; pc[i] = 0; stall[i] = 0; refill[i] = 0;
    end
  endtask

  // One clock: drive sources, snapshot expectations, advance the model, then let sources consume.
  task automatic tick(input bit rstn);
    int j;
    @(negedge clk);
    resetn = rstn;
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = (rem[i] > 0) && !stall[i];
      req_last[i]  = (rem[i] == 1);
      req_x[8*i +: 8]      = 8'(px[i]);
      req_y[7*i +: 7]      = 7'(py[i]);
      req_colour[3*i +: 3] = 3'(pc[i]);
    end
    #1;
    e_plot = m_plot; e_busy = m_hold; e_x = m_x; e_y = m_y; e_c = m_c; e_gid = m_gid;
    e_ready = (m_hold && req_valid[m_g]) ? 4'(1 << m_g) : 4'b0;
    if (!rstn) begin
      m_hold = 0; m_ptr = 3; m_idle = 0; m_gid = 0; m_plot = 0; m_x = 0; m_y = 0; m_c = 0;
    end else if (!m_hold) begin
      m_plot = 0;
      j = -1;
      for (int k = 1; k <= 4; k++)
        if (j < 0 && req_valid[(m_ptr + k) % 4]) j = (m_ptr + k) % 4;
      if (j >= 0) begin
        m_hold = 1; m_g = j; m_ptr = j; m_gid = j; m_idle = 0;
      end
    end else if (req_valid[m_g]) begin
      m_plot = on_screen(px[m_g], py[m_g]);
      m_x = px[m_g]; m_y = py[m_g]; m_c = pc[m_g]; m_idle = 0;
      if (rem[m_g] == 1) m_hold = 0;
    end else begin
      m_plot = 0;
      m_idle++;
      if (m_idle == TMO) begin m_hold = 0; m_idle = 0; end
    end
    for (int i = 0; i < 4; i++)
      if (req_valid[i] && req_ready[i]) begin
        rem[i]--;
        px[i] = (px[i] + 1) % 256;
        if (rem[i] == 0 && refill[i]) rem[i] = 1;
      end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    for (int i = 0; i < 4; i++) begin stall[i] = 0; refill[i] = 0; end
    while (((rem[0] + rem[1] + rem[2] + rem[3]) > 0 || busy) && n < 400) begin tick(1); n++; end
    checks++; if (n >= 400) begin errors++; $display("FAIL %s_drain: sources not drained in %0d cycles", tag, n); end
  endtask

  task automatic test_reset();
    clear_src();
    for (int i = 0; i < 4; i++) rem[i] = 1;
    tick(0); tick(0);
    checks++; if (plot !== 1'b0) begin errors++; $display("FAIL reset_plot: got %b exp 0", plot); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d exp 0", grant_id); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0000", req_ready); end
    checks++; if ({x, y, colour} !== 18'b0) begin errors++; $display("FAIL reset_pixel: got %0h/%0h/%0h exp 0", x, y, colour); end
    clear_src();
  endtask

  task automatic test_burst();
    clear_src();
    rem[0] = 31; px[0] = 19; py[0] = 40; pc[0] = 5;
    for (int c = 0; c <= 35; c++) begin
      tick(1);
      checks++; if (plot !== (c >= 2 && c <= 32)) begin errors++; $display("FAIL burst_plot c=%0d: got %b", c, plot); end
      checks++; if (busy !== (c >= 1 && c <= 31)) begin errors++; $display("FAIL burst_busy c=%0d: got %b", c, busy); end
      checks++; if (req_ready !== ((c >= 1 && c <= 31) ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL burst_ready c=%0d: got %b", c, req_ready); end
      if (c >= 2 && c <= 32) begin
        checks++; if ({x, y, colour} !== {8'(17 + c), 7'd40, 3'b101}) begin errors++; $display("FAIL burst_pixel c=%0d: got x=%0d y=%0d c=%0d exp x=%0d y=40 c=5", c, x, y, colour, 17 + c); end
      end
      if (c == 1) begin
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL burst_grant: got %0d exp 0", grant_id); end
      end
    end
    clear_src();
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    clear_src();
    tick(0);
    for (int i = 0; i < 4; i++) begin rem[i] = 1; refill[i] = 1; px[i] = 10 * i; py[i] = i; pc[i] = i; end
    for (int c = 0; c <= 9; c++) begin
      tick(1);
      checks++; if (busy !== 1'(c % 2)) begin errors++; $display("FAIL rr_busy c=%0d: got %b exp %0d", c, busy, c % 2); end
      checks++; if (plot !== (c >= 2 && c % 2 == 0)) begin errors++; $display("FAIL rr_plot c=%0d: got %b", c, plot); end
      if (c % 2 == 1) begin
        checks++; if (grant_id !== 2'(order[c/2])) begin errors++; $display("FAIL rr_order c=%0d: got %0d exp %0d", c, grant_id, order[c/2]); end
      end
    end
    for (int i = 0; i < 4; i++) rem[i] = 0;
    drain("rr");
  endtask

  task automatic test_stall();
    int scnt = 0, plots = 0;
    bit prev = 0;
    clear_src();
    rem[2] = 8; px[2] = 100; py[2] = 60; pc[2] = 2;
    for (int c = 0; c < 40; c++) begin
      if (8 - rem[2] == 3 && scnt < 10) begin stall[2] = 1; scnt++; end else stall[2] = 0;
      tick(1);
      if (plot === 1'b1) plots++;
      if (stall[2]) begin
        checks++; if (busy !== 1'b1 || grant_id !== 2'd2) begin errors++; $display("FAIL stall_grant c=%0d: got busy=%b id=%0d exp 1/2", c, busy, grant_id); end
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL stall_ready c=%0d: got %b", c, req_ready); end
      end
      if (prev) begin
        checks++; if (plot !== 1'b0) begin errors++; $display("FAIL stall_plot c=%0d: got %b exp 0", c, plot); end
      end
      prev = stall[2];
    end
    checks++; if (plots != 8) begin errors++; $display("FAIL stall_count: got %0d plots exp 8", plots); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_done: busy=%b exp 0", busy); end
    clear_src();
  endtask

  task automatic test_timeout();
    clear_src();
    tick(0);
    rem[1] = 5; px[1] = 10; py[1] = 11; pc[1] = 1;
    rem[3] = 2; px[3] = 30; py[3] = 31; pc[3] = 3;
    for (int c = 0; c <= 67; c++) begin
      stall[1] = (c >= 1);
      tick(1);
      if (c >= 1 && c <= 64) begin
        checks++; if (busy !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL tmo_hold c=%0d: got busy=%b id=%0d exp 1/1", c, busy, grant_id); end
      end
      if (c >= 1 && c <= 66) begin
        checks++; if (plot !== 1'b0) begin errors++; $display("FAIL tmo_plot c=%0d: got %b exp 0", c, plot); end
      end
      if (c == 65) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_release: busy=%b exp 0", busy); end
      end
      if (c == 66) begin
        checks++; if (busy !== 1'b1 || grant_id !== 2'd3) begin errors++; $display("FAIL tmo_next: got busy=%b id=%0d exp 1/3", busy, grant_id); end
      end
    end
    drain("tmo");
  endtask

  task automatic test_clip();
    clear_src();
    tick(0);
    rem[0] = 1; px[0] = 200; py[0] = 50; pc[0] = 7;
    for (int c = 0; c <= 3; c++) begin
      tick(1);
      if (c == 1) begin
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL clip_ready: got %b exp 0001", req_ready); end
      end
      if (c == 2) begin
`ifdef PLOT_ARB_CLIP_EN
        checks++; if (plot !== 1'b0) begin errors++; $display("FAIL clip_plot: got %b exp 0", plot); end
`else
        checks++; if (plot !== 1'b1 || x !== 8'd200) begin errors++; $display("FAIL clip_plot: got plot=%b x=%0d exp 1/200", plot, x); end
`endif
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clip_last: busy=%b exp 0", busy); end
      end
    end
    clear_src();
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    clear_src();
    tick(0);
    rem[0] = 31; px[0] = 19; py[0] = 40; pc[0] = 5;
    rem[2] = 3;  px[2] = 5;  py[2] = 6;  pc[2] = 4;
    while (31 - rem[0] < 9 && n < 40) begin tick(1); n++; end
    checks++; if (n >= 40) begin errors++; $display("FAIL rstmid_reach: burst stuck after %0d cycles", n); end
    tick(0);
    rem[0] = 31; px[0] = 19;
    tick(1);
    checks++; if (plot !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_abort: got plot=%b busy=%b exp 0/0", plot, busy); end
    tick(1);
    checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL rstmid_first: got busy=%b id=%0d exp 1/0", busy, grant_id); end
    drain("rstmid");
  endtask

  task automatic test_random();
    int slen[4] = '{0, 0, 0, 0};
    clear_src();
    tick(0);
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (rem[i] == 0 && $urandom_range(3, 0) == 0) begin
          rem[i] = $urandom_range(6, 1); px[i] = $urandom_range(255, 0);
          py[i] = $urandom_range(127, 0); pc[i] = $urandom_range(7, 0);
        end
        if (slen[i] > 0) begin stall[i] = 1; slen[i]--; end
        else begin
          stall[i] = 0;
          if ($urandom_range(299, 0) == 0) slen[i] = $urandom_range(80, 60);
          else if ($urandom_range(19, 0) == 0) slen[i] = $urandom_range(8, 1);
        end
      end
      tick(1);
      checks++; if (req_ready !== e_ready) begin errors++; $display("FAIL rnd_ready n=%0d: got %b exp %b", n, req_ready, e_ready); end
      checks++; if (plot !== e_plot || busy !== e_busy) begin errors++; $display("FAIL rnd_ctl n=%0d: got plot=%b busy=%b exp %b/%b", n, plot, busy, e_plot, e_busy); end
      checks++; if (grant_id !== 2'(e_gid)) begin errors++; $display("FAIL rnd_grant n=%0d: got %0d exp %0d", n, grant_id, e_gid); end
      checks++; if ({x, y, colour} !== {8'(e_x), 7'(e_y), 3'(e_c)}) begin errors++; $display("FAIL rnd_pixel n=%0d: got %0d/%0d/%0d exp %0d/%0d/%0d", n, x, y, colour, e_x, e_y, e_c); end
    end
    drain("rnd");
  endtask

  initial begin
    clear_src();
    test_reset();
    test_burst();
    test_round_robin();
    test_stall();
    test_timeout();
    test_clip();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/plot_arbiter.md
PLOT_ARBITER -- requirements
Module: plot_arbiter

Interface
REQ-001 Parameter X_MAX, default 159, SHALL be the largest on-screen x coordinate.
REQ-002 Parameter Y_MAX, default 119, SHALL be the largest on-screen y coordinate.
REQ-003 Parameter TIMEOUT, default 64, SHALL be the idle-cycle limit before a held grant is revoked (range 2..255).
REQ-004 clk  in  1  SHALL be the single rising-edge clock.
REQ-005 resetn  in  1  SHALL be the reset: synchronous, active-low, on clk.
REQ-006 req_valid  in  4  SHALL mark a pixel offered by requester i (bit i).
REQ-007 req_last  in  4  SHALL mark the offered pixel as the final pixel of requester i's burst.
REQ-008 req_x  in  32  SHALL carry the x coordinate for requester i in bits [8i+7:8i].
REQ-009 req_y  in  28  SHALL carry the y coordinate for requester i in bits [7i+6:7i].
REQ-010 req_colour  in  12  SHALL carry the colour for requester i in bits [3i+2:3i].
REQ-011 req_ready  out  4  SHALL mark that requester i's offered pixel is consumed this cycle.
REQ-012 plot  out  1  SHALL be the write strobe to the VGA adapter.
REQ-013 x, y, colour  out  8/7/3  SHALL be the pixel driven to the VGA adapter.
REQ-014 grant_id  out  2  SHALL be the index of the current or most recent grant holder.
REQ-015 busy  out  1  SHALL be high while any grant is held.

Function
REQ-016 The FSM SHALL have two states: ARB and HOLD.
REQ-017 ARB with req_valid==0 SHALL stay in ARB.
REQ-018 ARB with any valid SHALL go to HOLD, granting the first valid index found searching from (ptr+1) mod 4 upward.
REQ-019 On each grant, ptr SHALL take the granted index.
REQ-020 In ARB, req_ready SHALL be 0; the arbitration cycle consumes no pixel.
REQ-021 In HOLD, req_ready[g] SHALL equal req_valid[g] for the grantee g; all other bits SHALL be 0 (combinational).
REQ-022 A beat SHALL be accepted when req_valid[g] and req_ready[g] are both high.
REQ-023 An accepted beat SHALL appear on x/y/colour with plot=1 exactly one cycle later (registered outputs).
REQ-024 In every cycle with no accepted beat, the next cycle's plot SHALL be 0.
REQ-025 An accepted beat with req_last[g]=1 SHALL return the FSM to ARB next cycle.
REQ-026 In HOLD, an idle counter SHALL count consecutive cycles with req_valid[g]=0 and clear on any accepted beat.
REQ-027 When the idle counter reaches TIMEOUT, the FSM SHALL return to ARB without accepting a pixel.
REQ-028 Non-grantee valids SHALL be ignored and held off (ready 0) until arbitration.
REQ-029 A burst of N pixels SHALL occupy N+1 cycles minimum.
REQ-030 After a release, four continuously requesting sources SHALL each be granted once in any four consecutive grants.
REQ-031 busy SHALL be 1 in HOLD and 0 in ARB.
REQ-032 grant_id SHALL update on grant and hold its value in ARB.

Reset
REQ-033 While resetn=0, the FSM SHALL enter ARB with ptr=3 (requester 0 wins first), idle counter=0, plot=0, x=0, y=0, colour=0, grant_id=0, busy=0, req_ready=0.
REQ-034 Reset mid-burst SHALL abandon the burst with no further plot; the requester SHALL re-request.

Configuration
REQ-035 With PLOT_ARB_CLIP_EN defined, an accepted beat with x>X_MAX or y>Y_MAX SHALL be consumed (ready high, idle counter cleared, req_last honoured) but SHALL produce plot=0.
REQ-036 Without PLOT_ARB_CLIP_EN, every accepted beat SHALL produce plot=1 with unmodified coordinates.

Structure
REQ-037 Package plot_arb_pkg SHALL hold: NUM_REQ=4, X_W=8, Y_W=7, C_W=3, the ARB/HOLD state encoding, and the X_MAX/Y_MAX defaults.
REQ-038 Sub-module rr_pick SHALL be used as the combinational rotate-priority picker (4-bit valid, 2-bit ptr -> 2-bit index, found flag).

Verification
REQ-039 Reset release, then req_valid=0001 with a 31-pixel burst at x=19..49, y=40, colour=3'b101, last on pixel 31 -> grant_id=0 next cycle; plot high 31 consecutive cycles, starting 2 cycles after valid, x=19..49; busy drops one cycle after the last accept.
REQ-040 All four sources continuously valid, 1-pixel bursts (last=1) -> grant order 0,1,2,3,0; plot duty 50%.
REQ-041 Requester 2 granted; it drops valid for 10 cycles mid-burst -> no plot in those cycles, grant kept; resumes and completes.
REQ-042 Requester 1 granted then valid held 0, TIMEOUT=64 -> release after 64 idle cycles; pending requester 3 granted next cycle.
REQ-043 PLOT_ARB_CLIP_EN defined, beat x=200, y=50 accepted -> req_ready=1, plot stays 0; undefined -> plot=1 with x=200.
REQ-044 resetn=0 asserted at pixel 10 of a 31-pixel burst -> plot=0 and busy=0 the next cycle; the first grant after reset goes to requester 0.
